pong_clock_digits: RTL and testbench

PONG_CLOCK_DIGITS -- requirements
Module: pong_clock_digits

---
 rtl/pong_clock_digits.sv | 101 ++++++++++
 tb/tb_pong_clock_digits.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pong_clock_digits.sv
// pong_clock_digits: clock helpers and seven-segment digit glyph ROM for the
// pong display. Produces a divided square-wave clock, a half-rate pixel
// clock, and a registered 64x64 glyph lookup for the digits 0..9.
module pong_clock_digits #(
    parameter int DIVIDER = 500
) (
    input  logic        clk,
    input  logic        Reset,
    output logic        div_clk,
    output logic        pix_clk,
    input  logic [3:0]  digit,
    input  logic [11:0] address,
    output logic [2:0]  data
);

    // Terminal count of the divider. It wraps here, so the half-period is DIVIDER edges.
    localparam logic [15:0] CNT_LAST = 16'(DIVIDER - 1);

    logic [15:0] r_cnt;
    logic        r_divClk;
    logic        r_pixClk;
    logic [2:0]  r_data;

    logic [5:0]  w_row;
    logic [5:0]  w_col;
    logic [6:0]  w_segMask;
    logic [6:0]  w_segHit;
    logic        w_lit;

    assign w_row = address[11:6];
    assign w_col = address[5:0];

    // Divider counter. div_clk toggles on the same edge that the counter wraps to zero.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_cnt    <= 16'd0;
            r_divClk <= 1'b0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt    <= 16'd0;
            r_divClk <= ~r_divClk;
        end else begin
            r_cnt    <= r_cnt + 16'd1;
        end
    end

    // Half-rate pixel clock. It toggles on every system clock edge.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_pixClk <= 1'b0;
        end else begin
            r_pixClk <= ~r_pixClk;
        end
    end

    // Segments lit for each digit, bit order {g,f,e,d,c,b,a}. Codes 10..15 are blank.
    always_comb begin
        w_segMask = 7'b0000000;
        case (digit)
            4'd0:    w_segMask = 7'b0111111;
            4'd1:    w_segMask = 7'b0000110;
            4'd2:    w_segMask = 7'b1011011;
            4'd3:    w_segMask = 7'b1001111;
            4'd4:    w_segMask = 7'b1100110;
            4'd5:    w_segMask = 7'b1101101;
            4'd6:    w_segMask = 7'b1111101;
            4'd7:    w_segMask = 7'b0000111;
            4'd8:    w_segMask = 7'b1111111;
            4'd9:    w_segMask = 7'b1101111;
            default: w_segMask = 7'b0000000;
        endcase
    end

    // Geometric hit test of the pixel against each segment rectangle of the glyph cell.
    always_comb begin
        w_segHit    = 7'b0000000;
        w_segHit[0] = (w_row >= 6'd4)  && (w_row <= 6'd11) && (w_col >= 6'd12) && (w_col <= 6'd51);
        w_segHit[1] = (w_row >= 6'd4)  && (w_row <= 6'd31) && (w_col >= 6'd44) && (w_col <= 6'd51);
        w_segHit[2] = (w_row >= 6'd32) && (w_row <= 6'd59) && (w_col >= 6'd44) && (w_col <= 6'd51);
        w_segHit[3] = (w_row >= 6'd52) && (w_row <= 6'd59) && (w_col >= 6'd12) && (w_col <= 6'd51);
        w_segHit[4] = (w_row >= 6'd32) && (w_row <= 6'd59) && (w_col >= 6'd12) && (w_col <= 6'd19);
        w_segHit[5] = (w_row >= 6'd4)  && (w_row <= 6'd31) && (w_col >= 6'd12) && (w_col <= 6'd19);
        w_segHit[6] = (w_row >= 6'd28) && (w_row <= 6'd35) && (w_col >= 6'd12) && (w_col <= 6'd51);
    end

    // A pixel is lit if any enabled segment covers it. Overlaps simply stay lit.
    assign w_lit = |(w_segHit & w_segMask);

    // Registered ROM read. There is no enable, so a new lookup is made every cycle.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            r_data <= 3'b000;
        end else begin
            r_data <= w_lit ? 3'b111 : 3'b000;
        end
    end

    assign div_clk = r_divClk;
    assign pix_clk = r_pixClk;
    assign data    = r_data;

endmodule

// File: tb/tb_pong_clock_digits.sv
// Testbench for pong_clock_digits: three divider settings run side by side,
// with glyph reads compared against a rectangle-based reference model.
module tb_pong_clock_digits;

    logic        clk;
    logic        Reset;
    logic [3:0]  digit;
    logic [11:0] address;

    logic        divClk500, divClk250, divClk1;
    logic        pixClk500, pixClk250, pixClk1;
    logic [2:0]  data500, data250, data1;

    int checkCount;
    int errorCount;
    int modelEdges;
    bit monitorOn;

    // Segment rectangles in the order a..g, and the segment letters of each digit.
    localparam int SEG_R0 [7] = '{4,  4, 32, 52, 32,  4, 28};
    localparam int SEG_R1 [7] = '{11, 31, 59, 59, 59, 31, 35};
    localparam int SEG_C0 [7] = '{12, 44, 44, 12, 12, 12, 12};
    localparam int SEG_C1 [7] = '{51, 51, 51, 51, 19, 19, 51};
    string digitSegs [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                              "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

    pong_clock_digits #(.DIVIDER(500)) dut500 (
        .clk(clk), .Reset(Reset), .div_clk(divClk500), .pix_clk(pixClk500),
        .digit(digit), .address(address), .data(data500));

    pong_clock_digits #(.DIVIDER(250)) dut250 (
        .clk(clk), .Reset(Reset), .div_clk(divClk250), .pix_clk(pixClk250),
        .digit(digit), .address(address), .data(data250));

    pong_clock_digits #(.DIVIDER(1)) dut1 (
        .clk(clk), .Reset(Reset), .div_clk(divClk1), .pix_clk(pixClk1),
        .digit(digit), .address(address), .data(data1));

    // Free-running system clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference edge counter: clk edges seen since Reset was last released.
    always @(posedge clk or posedge Reset) begin
        if (Reset) modelEdges = 0;
        else       modelEdges = modelEdges + 1;
    end

    // Counts one comparison and reports it if observed differs from expected.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount = checkCount + 1;
        if (observed !== expected) begin
            errorCount = errorCount + 1;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    // Reference glyph: lit when the pixel lies inside any rectangle of the digit's segments.
    function automatic int refPixel(input int d, input int a);
        int    row, col, idx;
        string s;
        row = a / 64;
        col = a % 64;
        if (d > 9) return 0;
        s = digitSegs[d];
        for (int i = 0; i < s.len(); i++) begin
            idx = int'(s[i]) - 97;
            if (row >= SEG_R0[idx] && row <= SEG_R1[idx] &&
                col >= SEG_C0[idx] && col <= SEG_C1[idx])
                return 7;
        end
        return 0;
    endfunction

    // Presents one glyph read and waits until its registered result is visible.
    task automatic applyStimulus(input int d, input int a);
        @(negedge clk);
        digit   = 4'(d);
        address = 12'(a);
        @(posedge clk);
        #1;
    endtask

    // Presents a read and compares all three ROM copies against the model.
    task automatic romRead(input string tag, input int d, input int a);
        int exp;
        applyStimulus(d, a);
        exp = refPixel(d, a);
        checkOutput(tag, data500, exp);
        checkOutput({tag, "_250"}, data250, exp);
        checkOutput({tag, "_1"}, data1, exp);
    endtask

    // Cycle monitor for the clock outputs of all three divider settings.
    always begin
        @(posedge clk);
        #1;
        if (monitorOn && !Reset) begin
            checkOutput("div500", divClk500, (modelEdges / 500) % 2);
            checkOutput("div250", divClk250, (modelEdges / 250) % 2);
            checkOutput("div1",   divClk1,   modelEdges % 2);
            checkOutput("pix500", pixClk500, modelEdges % 2);
            checkOutput("pix250", pixClk250, modelEdges % 2);
            checkOutput("pix1",   pixClk1,   modelEdges % 2);
        end
    end

    // Main sequence: reset, glyph checks, then an asynchronous reset mid-count.
    initial begin
        int lit8, litModel, lit12, rise, waited;
        bit found;
        int dd, aa;
        int centreAddr [7];

        checkCount = 0;
        errorCount = 0;
        monitorOn  = 1'b0;
        Reset      = 1'b1;
        digit      = 4'd8;
        address    = 12'(30 * 64 + 30);

        // Held in reset with the clock running: everything must stay at zero.
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rstDiv500", divClk500, 0);
        checkOutput("rstPix500", pixClk500, 0);
        checkOutput("rstData500", data500, 0);
        checkOutput("rstDiv1", divClk1, 0);
        checkOutput("rstPix1", pixClk1, 0);
        checkOutput("rstData250", data250, 0);

        @(negedge clk);
        Reset     = 1'b0;
        monitorOn = 1'b1;

        // First read after release, then the named pixels.
        romRead("firstRead", 8, 30 * 64 + 30);
        checkOutput("d8r30c30", data500, 7);
        romRead("d8addr0", 8, 0);
        checkOutput("d8addr0Const", data500, 0);
        romRead("d1r8c48", 1, 8 * 64 + 48);
        checkOutput("d1r8c48Const", data500, 7);
        romRead("d1r8c30", 1, 8 * 64 + 30);
        checkOutput("d1r8c30Const", data500, 0);
        romRead("d0r30c30", 0, 30 * 64 + 30);
        checkOutput("d0r30c30Const", data500, 0);

        // Segment centres a..g for every digit.
        centreAddr = '{8 * 64 + 31, 16 * 64 + 47, 46 * 64 + 47, 56 * 64 + 31,
                       46 * 64 + 15, 16 * 64 + 15, 31 * 64 + 31};
        for (int d = 0; d < 10; d++)
            for (int s = 0; s < 7; s++)
                romRead($sformatf("centre_d%0d_s%0d", d, s), d, centreAddr[s]);

        // Full sweep of digit 8: every pixel plus the total lit count.
        lit8     = 0;
        litModel = 0;
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(8, a);
            checkOutput($sformatf("sweep8_%0d", a), data500, refPixel(8, a));
            if (data500 == 3'b111) lit8++;
            if (refPixel(8, a) == 7) litModel++;
        end
        checkOutput("sweep8Count", lit8, litModel);

        // Full sweep of a blank code.
        lit12 = 0;
        for (int a = 0; a < 4096; a++) begin
            applyStimulus(12, a);
            if (data500 != 3'b000) lit12++;
        end
        checkOutput("sweep12Count", lit12, 0);

        // Random reads, digit changing every cycle.
        for (int i = 0; i < 2000; i++) begin
            dd = int'($urandom_range(15));
            aa = int'($urandom_range(4095));
            romRead("random", dd, aa);
        end

        // Let the slowest divider complete at least ten full periods.
        waited = 0;
        while (modelEdges < 10000 && waited < 12000) begin
            @(posedge clk);
            waited++;
        end
        checkOutput("tenPeriodsReached", (modelEdges >= 10000) ? 1 : 0, 1);

        // Park on a lit pixel and find count 300 of a high half-period.
        applyStimulus(8, 30 * 64 + 30);
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(posedge clk);
            #1;
            if (modelEdges % 1000 == 800) found = 1'b1;
        end
        checkOutput("midCountFound", found ? 1 : 0, 1);
        #3;
        checkOutput("preResetDiv500", divClk500, 1);
        checkOutput("preResetData500", data500, 7);
        Reset = 1'b1;
        #1;
        checkOutput("asyncDiv500", divClk500, 0);
        checkOutput("asyncPix500", pixClk500, 0);
        checkOutput("asyncData500", data500, 0);
        checkOutput("asyncDiv250", divClk250, 0);
        checkOutput("asyncPix1", pixClk1, 0);

        // After release a full half-period must pass before the next rise.
        @(negedge clk);
        Reset = 1'b0;
        rise  = 0;
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #1;
            rise++;
            if (divClk500) break;
        end
        checkOutput("firstRiseAfterReset", rise, 500);

        repeat (600) @(posedge clk);
        #2;
        monitorOn = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
